frogger_game_ctrl: RTL

Game-phase sequencer for the Frogger datapath (lane shift registers plus frog position logic). It conditions the four raw active-low buttons into one-cycle move strobes and paces lane shifting from the VGA frame strobe. It runs the ATTRACT/PLAY/DYING/WIN/GAME_OVER state machine and owns lives, score and lane speed. It sits between the buttons and hvsync animate strobe on one side, and the frogger datapath and pixel writer on the other.

---
 rtl/frogger_pkg.sv | 39 +++
 rtl/frogger_btn_cond.sv | 74 +++++++
 rtl/frogger_game_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: constants and helpers shared by the Frogger game-phase controller.
//   - phase encoding (ATTRACT/PLAY/DYING/WIN/GAME_OVER) as plain 3-bit constants
//   - frog row constants and the frog start column used by the datapath
//   - counter widths and two small arithmetic helpers (saturating score,
//     clamped lane-period speed-up)
package frogger_pkg;

  localparam int CNT_W   = 8;  // phase, lane and repeat counters, lane period
  localparam int LIVES_W = 2;
  localparam int ROW_W   = 3;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_ATTRACT   = 3'd0;
  localparam logic [STATE_W-1:0] ST_PLAY      = 3'd1;
  localparam logic [STATE_W-1:0] ST_DYING     = 3'd2;
  localparam logic [STATE_W-1:0] ST_WIN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd4;

  localparam logic [ROW_W-1:0] GOAL_ROW  = 3'd0;
  localparam logic [ROW_W-1:0] START_ROW = 3'd7;

  localparam logic [7:0] FROG_START_COL = 8'b0001_0000;

  // Score counts crossings and sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lanes speed up by dec frames per win but never drop below floor_v.
  // The 9-bit compare keeps floor_v + dec from wrapping.
  function automatic logic [CNT_W-1:0] shrink_period(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] dec,
                                                     input logic [CNT_W-1:0] floor_v);
    if ({1'b0, p} >= ({1'b0, floor_v} + {1'b0, dec}))
      return p - dec;
    return floor_v;
  endfunction

endpackage

// File: rtl/frogger_btn_cond.sv
// frogger_btn_cond: conditions one raw active-low button into press pulses.
//   clk, reset (sync, active-low), frame_tick (one pulse per frame)
//   btn        raw active-low button, asynchronous
//   repeat_en  high while auto-repeat may fire (game is in PLAY)
//   press      one-cycle pulse per accepted press
// The raw level goes through a 2-FF synchroniser. The arm flag is set only at
// a frame_tick while the synced level reads released, so contact bounce inside
// one frame yields a single press.
// Optional feature macro: AUTO_REPEAT_EN (held button re-fires every
// REPEAT_FRAMES frame_ticks while repeat_en is high).
module frogger_btn_cond
  import frogger_pkg::*;
#(
  parameter int REPEAT_FRAMES = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic btn,
  input  logic repeat_en,
  output logic press
);

  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_FRAMES - 1);

  logic sync1;
  logic sync2;
  logic armed;
  logic first_press;

  // sync2 == 0 means held down.
  assign first_press = ~sync2 & armed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      armed <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (frame_tick && sync2)
        armed <= 1'b1;
      else if (first_press)
        armed <= 1'b0;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_fire;

  // Armed stays low for as long as the button is held after its first
  // press, so ~armed & ~sync2 marks the held-after-press interval.
  assign rep_fire = repeat_en & ~sync2 & ~armed & frame_tick & (rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt <= '0;
    end else if (sync2 || !repeat_en) begin
      rep_cnt <= '0;
    end else if (frame_tick && !armed) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 8'd1;
    end
  end

  assign press = first_press | rep_fire;
`else
  logic [CNT_W:0] unused_repeat;
  assign unused_repeat = {repeat_en, REP_LAST};
  assign press = first_press;
`endif

endmodule

// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl: game-phase sequencer for the Frogger datapath.
//   clk, reset (sync, active-low), frame_tick (animate strobe, once per frame)
//   btn_up/down/left/right  raw active-low buttons
//   frog_row   frog vertical position (0 = goal, 7 = start)
//   collision  level, frog overlaps a car
//   move_*     one-cycle move strobes (PLAY only, up > down > left > right)
//   lane_step  one-cycle lane shift strobe, paced by the lane period
//   lane_reset / frog_reset  one-cycle reload strobes for the datapath
//   state      current phase (frogger_pkg encoding), registered
//   lives, score, flash  registered status for the pixel writer
// All strobes are single-cycle pulses with no handshake; the datapath acts on
// them in the cycle they are high.
// Optional feature macro: AUTO_REPEAT_EN (held buttons auto-repeat in PLAY).
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int LANE_PERIOD   = 60,
  parameter int LANE_MIN      = 15,
  parameter int LANE_DEC      = 5,
  parameter int DEAD_FRAMES   = 90,
  parameter int WIN_FRAMES    = 120,
  parameter int GO_FRAMES     = 180,
  parameter int LIVES         = 3,
  parameter int REPEAT_FRAMES = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic [ROW_W-1:0]   frog_row,
  input  logic               collision,
  output logic               move_up,
  output logic               move_down,
  output logic               move_left,
  output logic               move_right,
  output logic               lane_step,
  output logic               lane_reset,
  output logic               frog_reset,
  output logic [STATE_W-1:0] state,
  output logic [LIVES_W-1:0] lives,
  output logic [7:0]         score,
  output logic               flash
);

  localparam logic [CNT_W-1:0]   PERIOD_INIT = CNT_W'(LANE_PERIOD);
  localparam logic [CNT_W-1:0]   PERIOD_MIN  = CNT_W'(LANE_MIN);
  localparam logic [CNT_W-1:0]   PERIOD_DEC  = CNT_W'(LANE_DEC);
  localparam logic [CNT_W-1:0]   DEAD_LAST   = CNT_W'(DEAD_FRAMES);
  localparam logic [CNT_W-1:0]   WIN_LAST    = CNT_W'(WIN_FRAMES);
  localparam logic [CNT_W-1:0]   GO_LAST     = CNT_W'(GO_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);

  // press[0]=up, [1]=down, [2]=left, [3]=right
  logic [3:0]         press;
  logic               any_press;
  logic               in_play;
  logic [3:0]         move_sel;
  logic [CNT_W-1:0]   phase;
  logic [CNT_W-1:0]   lane_cnt;
  logic [CNT_W-1:0]   period;
  logic               lane_active;
  logic               lane_hit;
  logic [STATE_W-1:0] next_state;
  logic               new_game;
  logic               lose_life;
  logic               win_entry;
  logic               lane_reload;
  logic               frog_home;

  // The start column belongs to the datapath; this block only sequences it.
  logic [7:0] unused_start_col;
  assign unused_start_col = FROG_START_COL;

  assign in_play = (state == ST_PLAY);

  frogger_btn_cond #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_btn_up (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_up),
    .repeat_en(in_play), .press(press[0]));
  frogger_btn_cond #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_btn_down (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_down),
    .repeat_en(in_play), .press(press[1]));
  frogger_btn_cond #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_btn_left (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_left),
    .repeat_en(in_play), .press(press[2]));
  frogger_btn_cond #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_btn_right (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn_right),
    .repeat_en(in_play), .press(press[3]));

  assign any_press = |press;

  // Priority picks one press first; an up at the goal row or a down at the
  // start row is then dropped rather than handing over to the next button.
  always_comb begin
    move_sel = 4'b0000;
    if (in_play) begin
      if (press[0])      move_sel[0] = (frog_row != GOAL_ROW);
      else if (press[1]) move_sel[1] = (frog_row != START_ROW);
      else if (press[2]) move_sel[2] = 1'b1;
      else if (press[3]) move_sel[3] = 1'b1;
    end
  end

  assign lane_active = (state == ST_ATTRACT) || (state == ST_PLAY);
  assign lane_hit    = frame_tick & lane_active & (lane_cnt == period - 8'd1);

  always_comb begin
    next_state  = state;
    new_game    = 1'b0;
    lose_life   = 1'b0;
    win_entry   = 1'b0;
    lane_reload = 1'b0;
    frog_home   = 1'b0;
    case (state)
      ST_ATTRACT: begin
        if (any_press) begin
          next_state  = ST_PLAY;
          new_game    = 1'b1;
          lane_reload = 1'b1;
          frog_home   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          next_state = ST_DYING;
          lose_life  = 1'b1;
        end else if (frog_row == GOAL_ROW) begin
          next_state = ST_WIN;
          win_entry  = 1'b1;
        end
      end
      ST_DYING: begin
        if (phase == DEAD_LAST) begin
          if (lives == '0) begin
            next_state = ST_GAME_OVER;
          end else begin
            next_state = ST_PLAY;
            frog_home  = 1'b1;
          end
        end
      end
      ST_WIN: begin
        if (phase == WIN_LAST) begin
          next_state  = ST_PLAY;
          frog_home   = 1'b1;
          lane_reload = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (any_press && (phase >= GO_LAST))
          next_state = ST_ATTRACT;
      end
      default: next_state = ST_ATTRACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_ATTRACT;
      lives      <= LIVES_INIT;
      score      <= 8'd0;
      period     <= PERIOD_INIT;
      lane_cnt   <= '0;
      phase      <= '0;
      flash      <= 1'b0;
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      lane_step  <= 1'b0;
      lane_reset <= 1'b0;
      frog_reset <= 1'b0;
    end else begin
      state      <= next_state;
      move_up    <= move_sel[0];
      move_down  <= move_sel[1];
      move_left  <= move_sel[2];
      move_right <= move_sel[3];
      lane_step  <= lane_hit;
      lane_reset <= lane_reload;
      frog_reset <= frog_home;

      // Reloaded lane patterns restart the shift cadence from zero.
      if (lane_reload)
        lane_cnt <= '0;
      else if (frame_tick && lane_active)
        lane_cnt <= lane_hit ? '0 : lane_cnt + 8'd1;

      // GAME_OVER parks the phase counter at GO_LAST so the press gate stays open.
      if (next_state != state)
        phase <= '0;
      else if (frame_tick && !((state == ST_GAME_OVER) && (phase >= GO_LAST)))
        phase <= phase + 8'd1;

      if (new_game) begin
        lives  <= LIVES_INIT;
        score  <= 8'd0;
        period <= PERIOD_INIT;
      end
      if (lose_life)
        lives <= lives - 2'd1;
      if (win_entry) begin
        score  <= sat_inc8(score);
        period <= shrink_period(period, PERIOD_DEC, PERIOD_MIN);
      end

      if (state == ST_DYING) begin
        if (next_state != ST_DYING)
          flash <= 1'b0;
        else if (frame_tick && (phase[2:0] == 3'd7))
          flash <= ~flash;
      end
    end
  end

endmodule
